// File: rtl/jtag_host_shifter.sv
// Host-side JTAG scan engine: runs one IR/DR scan or TAP reset per command,
// generating TCK/TMS/TDI from clk_i and collecting TDO into a right-aligned response.
module jtag_host_shifter #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  localparam int unsigned CntW = LEN_W + 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0]  DivMax = DivW'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(DATA_W);

  localparam logic [1:0] OpDr  = 2'b00;
  localparam logic [1:0] OpIr  = 2'b01;
  localparam logic [1:0] OpRst = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StDone} state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   cap_q;
  logic [DATA_W-1:0]   rsp_q;
  logic [CntW-1:0]     tck_idx_q;
  logic [DivW-1:0]     div_q;
  logic                tck_q;
  logic                tms_q;
  logic                tdi_q;
  logic                done_q;

  logic [CntW-1:0]     pre_len;
  logic [CntW-1:0]     post_idx;
  logic [CntW-1:0]     last_idx;
  logic [CntW-1:0]     nxt_idx;
  logic                cur_shift;
  logic                nxt_shift;
  logic                nxt_tms;
  logic                nxt_tdi;
  logic [LEN_W-1:0]    len_clamped;
  logic [LEN_W-1:0]    rsp_shamt;

  // A TCK is a shift TCK when it falls in [pre, post) of the sequence.
  function automatic logic is_shift(input logic [1:0] op, input logic [CntW-1:0] idx,
                                    input logic [CntW-1:0] pre, input logic [CntW-1:0] post);
    return (op != OpRst) && (idx >= pre) && (idx < post);
  endfunction

  function automatic logic tms_at(input logic [1:0] op, input logic [CntW-1:0] idx,
                                  input logic [CntW-1:0] pre, input logic [CntW-1:0] post);
    logic tms;
    if (op == OpRst) begin
      tms = (idx < CntW'(5));
    end else if (idx < pre) begin
      tms = (idx == '0) || ((op == OpIr) && (idx == CntW'(1)));
    end else if (idx < post) begin
      tms = (idx == post - CntW'(1));
    end else begin
      tms = (idx == post);
    end
    return tms;
  endfunction

  always_comb begin
    pre_len   = (op_q == OpIr) ? CntW'(4) : CntW'(3);
    post_idx  = pre_len + CntW'(len_q);
    last_idx  = (op_q == OpRst) ? CntW'(5) : post_idx + CntW'(1);
    nxt_idx   = (state_q == StScan) ? tck_idx_q + CntW'(1) : '0;
    cur_shift = (state_q == StScan) && is_shift(op_q, tck_idx_q, pre_len, post_idx);
    nxt_shift = is_shift(op_q, nxt_idx, pre_len, post_idx);
    nxt_tms   = tms_at(op_q, nxt_idx, pre_len, post_idx);
    // data_q is shifted at the end of each shift TCK, so look one bit ahead here.
    nxt_tdi   = nxt_shift & (cur_shift ? data_q[1] : data_q[0]);
    rsp_shamt = MaxLen - len_q;
    if (cmd_len_i == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cmd_len_i > MaxLen) begin
      len_clamped = MaxLen;
    end else begin
      len_clamped = cmd_len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= OpDr;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      rsp_q     <= '0;
      tck_idx_q <= '0;
      div_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            op_q      <= cmd_op_i;
            len_q     <= len_clamped;
            data_q    <= cmd_data_i;
            cap_q     <= '0;
            tck_idx_q <= '0;
            div_q     <= '0;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (op_q == OpRsv) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StScan;
            tck_q   <= 1'b0;
            div_q   <= '0;
            tms_q   <= nxt_tms;
            tdi_q   <= nxt_tdi;
          end
        end
        StScan: begin
          if (div_q != DivMax) begin
            div_q <= div_q + DivW'(1);
          end else if (!tck_q) begin
            // Last clk of the low phase: sample TDO ahead of the rising edge.
            div_q <= '0;
            tck_q <= 1'b1;
            if (cur_shift) begin
              cap_q <= {tdo_i, cap_q[DATA_W-1:1]};
            end
          end else begin
            div_q <= '0;
            tck_q <= 1'b0;
            if (cur_shift) begin
              data_q <= data_q >> 1;
            end
            if (tck_idx_q == last_idx) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              rsp_q   <= cap_q >> rsp_shamt;
              tms_q   <= 1'b0;
              tdi_q   <= 1'b0;
            end else begin
              tck_idx_q <= nxt_idx;
              tms_q     <= nxt_tms;
              tdi_q     <= nxt_tdi;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign done_o      = done_q;
  assign rsp_data_o  = rsp_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Bench for jtag_host_shifter: a behavioural target TAP on the main instance, a
// sequence/latency model checked every cycle, and a fast-divider instance for async reset.
module tb_jtag_host_shifter;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned DataW  = 32;
  localparam int unsigned LenW   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [LenW-1:0]  cmd_len = '0;
  logic [DataW-1:0] cmd_data = '0;
  logic             cmd_ready, done, tck, tms, tdi, tdo;
  logic [DataW-1:0] rsp;

  logic             rst_f = 1'b1;
  logic             valid_f = 1'b0;
  logic [1:0]       op_f = 2'b00;
  logic [LenW-1:0]  len_f = '0;
  logic [DataW-1:0] data_f = '0;
  logic             ready_f, done_f, tck_f, tms_f, tdi_f;
  logic [DataW-1:0] rsp_f;

  jtag_host_shifter #(.CLK_DIV(ClkDiv), .DATA_W(DataW), .LEN_W(LenW)) u_dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data), .done_o(done),
    .rsp_data_o(rsp), .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
  );

  jtag_host_shifter #(.CLK_DIV(1), .DATA_W(DataW), .LEN_W(LenW)) u_dut_fast (
    .clk_i(clk), .rst_i(rst_f), .cmd_valid_i(valid_f), .cmd_ready_o(ready_f),
    .cmd_op_i(op_f), .cmd_len_i(len_f), .cmd_data_i(data_f), .done_o(done_f),
    .rsp_data_o(rsp_f), .tck_o(tck_f), .tms_o(tms_f), .tdi_o(tdi_f), .tdo_i(1'b0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Target TAP: 16-state controller, 4-bit IR, 32-bit loopback DR.
  int          tap_st = 1;
  logic [3:0]  ir = 4'h0, ir_sr = 4'h0;
  logic [31:0] dr = 32'h1234_5678, dr_sr = 32'h0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      0:       return m ? 0 : 1;
      1:       return m ? 2 : 1;
      2:       return m ? 9 : 3;
      3, 4:    return m ? 5 : 4;
      5:       return m ? 8 : 6;
      6:       return m ? 7 : 6;
      7:       return m ? 8 : 4;
      8, 15:   return m ? 2 : 1;
      9:       return m ? 0 : 10;
      10, 11:  return m ? 12 : 11;
      12:      return m ? 15 : 13;
      13:      return m ? 14 : 13;
      default: return m ? 15 : 11;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      0:  ir <= 4'h0;
      3:  dr_sr <= dr;
      4:  dr_sr <= {tdi, dr_sr[31:1]};
      8:  dr <= dr_sr;
      10: ir_sr <= ir;
      11: ir_sr <= {tdi, ir_sr[3:1]};
      15: ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  assign tdo = (tap_st == 4) ? dr_sr[0] : (tap_st == 11) ? ir_sr[0] : 1'b0;

  // Expected per-TCK TMS/TDI/shift lists for the command in flight.
  bit          e_tms[$], e_tdi[$], e_sh[$];
  int          e_lat;
  logic [1:0]  e_op;

  task automatic push(input bit m, input bit t, input bit s);
    e_tms.push_back(m);
    e_tdi.push_back(t);
    e_sh.push_back(s);
  endtask

  task automatic build(input logic [1:0] op, input int len, input logic [31:0] d);
    int n;
    n = (len == 0) ? 1 : ((len > 32) ? 32 : len);
    e_tms.delete();
    e_tdi.delete();
    e_sh.delete();
    e_op = op;
    if (op == 2'b00 || op == 2'b01) begin
      push(1, 0, 0);
      if (op == 2'b01) push(1, 0, 0);
      push(0, 0, 0);
      push(0, 0, 0);
      for (int i = 0; i < n; i++) push(i == n - 1, d[i], 1);
      push(1, 0, 0);
      push(0, 0, 0);
    end else if (op == 2'b10) begin
      for (int i = 0; i < 6; i++) push(i < 5, 0, 0);
    end
    e_lat = e_tms.size() * 2 * ClkDiv + 1;
  endtask

  int          ncyc = 0, acc_at = 0, rise_cnt = 0, sh_k = 0;
  int          last_lat = 0, obs_rises = 0, done_cyc = 0, done_count = 0;
  bit          busy = 0;
  logic        prev_tck = 0, prev_done = 0, prev_tms = 0, prev_tdi = 0, tdo_low = 0;
  logic [31:0] got_rsp = '0, hold_rsp = '0;
  logic [63:0] obs_tms = '0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      busy = 0;
      hold_rsp = '0;
      prev_tck = 0;
      prev_done = 0;
    end else begin
      if (prev_done) begin
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", cmd_ready, 1);
      end
      if (!busy) chk("tck_idle_low", tck, 0);
      if (busy && tck && prev_tck) begin
        chk("tms_stable_high", tms, prev_tms);
        chk("tdi_stable_high", tdi, prev_tdi);
      end
      if (busy && tck && !prev_tck) begin
        if (rise_cnt < e_tms.size()) begin
          chk("tms_seq", tms, e_tms[rise_cnt]);
          chk("tdi_seq", tdi, e_tdi[rise_cnt]);
          if (e_sh[rise_cnt]) begin
            got_rsp[sh_k] = tdo_low;
            sh_k++;
          end
        end else begin
          chk("extra_tck", rise_cnt, e_tms.size());
        end
        if (rise_cnt < 64) obs_tms[rise_cnt] = tms;
        rise_cnt++;
      end
      if (done) begin
        chk("done_expected", busy, 1);
        last_lat = ncyc - acc_at - 1;
        chk("latency", last_lat, e_lat);
        chk("tck_count", rise_cnt, e_tms.size());
        chk("tck_low_at_done", tck, 0);
        if (e_op != 2'b11) begin
          chk("tms_idle_after", tms, 0);
          hold_rsp = got_rsp;
        end
        chk("rsp_at_done", rsp, hold_rsp);
        obs_rises = rise_cnt;
        done_cyc = ncyc;
        done_count++;
        busy = 0;
      end else begin
        chk("rsp_hold", rsp, hold_rsp);
      end
      if (!tck) tdo_low = tdo;
      if (cmd_valid && cmd_ready) begin
        busy = 1;
        acc_at = ncyc;
        build(cmd_op, int'(cmd_len), cmd_data);
        rise_cnt = 0;
        sh_k = 0;
        got_rsp = '0;
        obs_tms = '0;
      end
      prev_tck = tck;
      prev_done = done;
      prev_tms = tms;
      prev_tdi = tdi;
    end
  end

  task automatic send(input logic [1:0] op, input int len, input logic [31:0] d);
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = LenW'(len);
    cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", n < 50, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_count == base && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", done_count > base, 1);
  endtask

  int          base, first_done, n, nd;
  logic [63:0] obs_f;
  logic        prev_f;

  initial begin
    #23;
    rst = 1'b0;
    rst_f = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rsp", rsp, 0);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);

    base = done_count;
    send(2'b10, 0, 32'hFFFF_FFFF);
    wait_done(base);
    chk("reset_tms", obs_tms[5:0], 6'b011111);
    chk("reset_rises", obs_rises, 6);
    chk("reset_latency", last_lat, 25);

    base = done_count;
    send(2'b01, 4, 32'h5);
    wait_done(base);
    chk("ir1_tms", obs_tms[9:0], 10'b0110000011);
    chk("ir1_rsp", rsp, 32'h0);
    chk("ir1_target", ir, 4'h5);

    base = done_count;
    send(2'b01, 4, 32'hA);
    wait_done(base);
    chk("ir2_rsp", rsp, 32'h5);
    chk("ir2_target", ir, 4'hA);

    base = done_count;
    send(2'b00, 32, 32'hDEAD_BEEF);
    wait_done(base);
    chk("dr32_rises", obs_rises, 37);
    chk("dr32_rsp", rsp, 32'h1234_5678);
    chk("dr32_target", dr, 32'hDEAD_BEEF);

    base = done_count;
    send(2'b00, 0, 32'h1);
    wait_done(base);
    chk("len0_tms", obs_tms[5:0], 6'b011001);
    chk("len0_rsp", rsp, 32'h1);

    base = done_count;
    send(2'b00, 40, 32'hCAFE_F00D);
    wait_done(base);
    chk("len40_rises", obs_rises, 37);
    chk("len40_rsp", rsp, 32'hEF56_DF77);
    chk("len40_target", dr, 32'hCAFE_F00D);

    base = done_count;
    send(2'b11, 8, 32'h0);
    wait_done(base);
    chk("rsv_latency", last_lat, 1);
    chk("rsv_rises", obs_rises, 0);
    chk("rsv_rsp", rsp, 32'hEF56_DF77);

    // Back-to-back: valid stays high, second command taken the cycle after done.
    base = done_count;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_len = LenW'(8);
    cmd_data = 32'h3C;
    wait_done(base);
    first_done = done_cyc;
    #1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(base + 1);
    chk("b2b_gap", done_cyc - first_done, 55);

    // Command presented mid-scan must be ignored.
    base = done_count;
    send(2'b00, 8, 32'hA5);
    repeat (10) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_len = LenW'(4);
    cmd_data = 32'hFF;
    repeat (5) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(base);
    repeat (4) @(posedge clk);
    chk("midscan_done_count", done_count - base, 1);
    chk("midscan_rises", obs_rises, 13);

    // Async reset mid-shift on the CLK_DIV=1 instance.
    @(posedge clk);
    #1;
    valid_f = 1'b1;
    op_f = 2'b00;
    len_f = LenW'(16);
    data_f = 32'hFFFF;
    @(posedge clk);
    #1;
    valid_f = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_f = 1'b1;
    #1;
    chk("abort_tck", tck_f, 0);
    chk("abort_tms", tms_f, 1);
    chk("abort_ready", ready_f, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_f = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_f || tck_f) nd++;
    end
    chk("abort_quiet", nd, 0);
    chk("abort_ready_after", ready_f, 1);

    @(posedge clk);
    #1;
    valid_f = 1'b1;
    op_f = 2'b10;
    @(posedge clk);
    #1;
    valid_f = 1'b0;
    n = 0;
    nd = 0;
    obs_f = '0;
    prev_f = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (tck_f && !prev_f) begin
        if (nd < 64) obs_f[nd] = tms_f;
        nd++;
      end
      prev_f = tck_f;
      if (done_f) break;
    end
    chk("fast_reset_latency", n - 1, 13);
    chk("fast_reset_rises", nd, 6);
    chk("fast_reset_tms", obs_f[5:0], 6'b011111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
